// File: rtl/matrix_result_streamer.sv
// Drains an n x n result matrix row-major from the multiplier onto a tagged valid/ready stream.
// Optional build macro STREAM_CHECKSUM_EN adds a wrapping checksum of all delivered elements.
module matrix_result_streamer #(
  parameter  int unsigned n          = 4,
  parameter  int unsigned DATA_W     = 32,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned n_len      = $clog2(n)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [n_len-1:0]  z_i,
  output logic [n_len-1:0]  z_j,
  input  logic [DATA_W-1:0] z_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [n_len-1:0]  m_row,
  output logic [n_len-1:0]  m_col,
  output logic              m_last,
  output logic              busy,
`ifdef STREAM_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic              done
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, DONE} state_e;

  typedef struct packed {
    logic              last;
    logic [n_len-1:0]  row;
    logic [n_len-1:0]  col;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e            state_q, state_d;
  logic [n_len-1:0]  zi_q, zi_d, zj_q, zj_d;
  logic              infl_q, infl_d;
  logic [n_len-1:0]  tag_row_q, tag_row_d, tag_col_q, tag_col_d;
  logic              tag_last_q, tag_last_d;
  entry_t            fifo_q [FIFO_DEPTH];
  entry_t            fifo_d [FIFO_DEPTH];
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              m_valid_q, m_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef STREAM_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  logic              issue_c, clear_c, pop_c, push_c, room_c, last_addr_c;
  logic [AW-1:0]     wr_idx_c;

  // Head of the FIFO is always entry 0, so the stream outputs come straight from flops.
  assign z_i     = zi_q;
  assign z_j     = zj_q;
  assign m_valid = m_valid_q;
  assign m_data  = fifo_q[0].data;
  assign m_row   = fifo_q[0].row;
  assign m_col   = fifo_q[0].col;
  assign m_last  = fifo_q[0].last;
  assign busy    = busy_q;
  assign done    = done_q;
`ifdef STREAM_CHECKSUM_EN
  assign checksum = sum_q;
`endif

  assign pop_c       = m_valid_q & m_ready;
  assign push_c      = infl_q;
  // Words already buffered plus the one in flight must leave room for another issue.
  assign room_c      = ({1'b0, cnt_q} + (CW+1)'(infl_q)) < (CW+1)'(FIFO_DEPTH);
  assign last_addr_c = (zi_q == n_len'(n - 1)) && (zj_q == n_len'(n - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   if (issue_c && last_addr_c) state_d = FLUSH;
      FLUSH:   if (pop_c && fifo_q[0].last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The start cycle itself issues (0,0), which is already on z_i/z_j while idle.
  always_comb begin
    issue_c = 1'b0;
    clear_c = 1'b0;
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    unique case (state_q)
      IDLE:    begin issue_c = start; clear_c = start; end
      ISSUE:   issue_c = room_c;
      default: issue_c = 1'b0;
    endcase
  end

  always_comb begin
    zi_d       = zi_q;
    zj_d       = zj_q;
    infl_d     = issue_c;
    tag_row_d  = tag_row_q;
    tag_col_d  = tag_col_q;
    tag_last_d = tag_last_q;
    fifo_d     = fifo_q;
    cnt_d      = cnt_q + CW'(push_c) - CW'(pop_c);
    wr_idx_c   = AW'(cnt_q - CW'(pop_c));
    if (issue_c) begin
      tag_row_d  = zi_q;
      tag_col_d  = zj_q;
      tag_last_d = last_addr_c;
      if (zj_q == n_len'(n - 1)) begin
        zj_d = '0;
        zi_d = (zi_q == n_len'(n - 1)) ? '0 : zi_q + n_len'(1);
      end else begin
        zj_d = zj_q + n_len'(1);
      end
    end
    if (pop_c) begin
      for (int k = 0; k < FIFO_DEPTH - 1; k++) fifo_d[k] = fifo_q[k+1];
    end
    if (push_c) begin
      fifo_d[wr_idx_c] = '{last: tag_last_q, row: tag_row_q, col: tag_col_q, data: z_out};
    end
    m_valid_d = (cnt_d != '0);
  end

`ifdef STREAM_CHECKSUM_EN
  always_comb begin
    sum_d = sum_q;
    if (clear_c)    sum_d = '0;
    else if (pop_c) sum_d = sum_q + fifo_q[0].data;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zi_q       <= '0;
      zj_q       <= '0;
      infl_q     <= 1'b0;
      tag_row_q  <= '0;
      tag_col_q  <= '0;
      tag_last_q <= 1'b0;
      for (int k = 0; k < FIFO_DEPTH; k++) fifo_q[k] <= '0;
      cnt_q      <= '0;
      m_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef STREAM_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      zi_q       <= zi_d;
      zj_q       <= zj_d;
      infl_q     <= infl_d;
      tag_row_q  <= tag_row_d;
      tag_col_q  <= tag_col_d;
      tag_last_q <= tag_last_d;
      fifo_q     <= fifo_d;
      cnt_q      <= cnt_d;
      m_valid_q  <= m_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef STREAM_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Self-checking bench for matrix_result_streamer: multiplier read model plus row-major expected-stream queue.
module tb_matrix_result_streamer;

  localparam int N = 4, DW = 32, DEPTH = 4, NL = 2;

  logic          clk = 1'b0;
  logic          rst, start, m_ready;
  logic [NL-1:0] z_i, z_j, m_row, m_col;
  logic [DW-1:0] z_out, m_data;
  logic          m_valid, m_last, busy, done;
`ifdef STREAM_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  logic [DW-1:0] zmem [N*N];
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [DW-1:0] d;
    int            r;
    int            c;
    bit            l;
  } exp_t;

  always #5 clk = ~clk;

  // Multiplier result memory with one cycle of read latency.
  always @(posedge clk) z_out <= zmem[int'(z_i) * N + int'(z_j)];

  matrix_result_streamer #(.n(N), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .z_i(z_i), .z_j(z_j), .z_out(z_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_row(m_row), .m_col(m_col), .m_last(m_last), .busy(busy),
`ifdef STREAM_CHECKSUM_EN
    .checksum(checksum),
`endif
    .done(done)
  );

  function automatic void fill_formula();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) zmem[i*N+j] = DW'(16 * i + j + 1);
  endfunction

  function automatic void fill_random();
    for (int k = 0; k < N*N; k++) zmem[k] = $urandom;
  endfunction

  function automatic logic [DW-1:0] model_sum();
    logic [DW-1:0] s = '0;
    for (int k = 0; k < N*N; k++) s = s + zmem[k];
    return s;
  endfunction

  // mode: 0 ready=1, 1 one-on/two-off, 2 random, 3 held low for 20 cycles.
  task automatic drain(input int mode, input int stop_beats, input int extra_start,
                       output int done_cyc, output int first_v, output int nbeats,
                       output logic [DW-1:0] cks);
    exp_t q[$];
    exp_t e;
    logic [DW-1:0] pd;
    logic [NL-1:0] pr, pc;
    logic pl, pv, prdy, rdy;
    int lin;
    q.delete();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) q.push_back('{zmem[i*N+j], i, j, (i == N-1 && j == N-1)});
    done_cyc = -1; first_v = -1; nbeats = 0; cks = '0;
    pv = 1'b0; prdy = 1'b0; pd = '0; pr = '0; pc = '0; pl = 1'b0;
    @(negedge clk);
    start = 1'b1;
    m_ready = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start = (c == extra_start);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (c % 3 == 0);
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (c > 20);
      endcase
      m_ready = rdy;
      if (mode == 3 && c == 20) begin
        checks++;
        if (z_i !== 2'd1 || z_j !== 2'd0 || m_valid !== 1'b1 || nbeats != 0) begin
          failures++;
          $display("FAIL stall_freeze got z=(%0d,%0d) valid=%0b beats=%0d want z=(1,0) valid=1 beats=0",
                   z_i, z_j, m_valid, nbeats);
        end
      end
      if (pv && !prdy) begin
        checks++;
        if ({m_valid, m_data, m_row, m_col, m_last} !== {1'b1, pd, pr, pc, pl}) begin
          failures++;
          $display("FAIL stall_stable cycle %0d got v=%0b d=%0h r=%0d c=%0d l=%0b want v=1 d=%0h r=%0d c=%0d l=%0b",
                   c, m_valid, m_data, m_row, m_col, m_last, pd, pr, pc, pl);
        end
      end
      if (busy && !done) begin
        lin = int'(z_i) * N + int'(z_j);
        if (lin != 0) begin
          checks++;
          if (lin > nbeats + DEPTH) begin
            failures++;
            $display("FAIL lookahead cycle %0d got issued=%0d consumed=%0d want issued<=%0d",
                     c, lin, nbeats, nbeats + DEPTH);
          end
        end
      end
      if (m_valid && first_v < 0) first_v = c;
      if (m_valid && rdy) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL extra_beat got d=%0h r=%0d c=%0d want no beat", m_data, m_row, m_col);
        end else begin
          e = q.pop_front();
          if (m_data !== e.d || int'(m_row) !== e.r || int'(m_col) !== e.c || m_last !== e.l) begin
            failures++;
            $display("FAIL beat%0d got d=%0h r=%0d c=%0d l=%0b want d=%0h r=%0d c=%0d l=%0b",
                     nbeats, m_data, m_row, m_col, m_last, e.d, e.r, e.c, e.l);
          end
        end
        nbeats++;
      end
      if (done && done_cyc < 0) begin
        done_cyc = c;
`ifdef STREAM_CHECKSUM_EN
        cks = checksum;
`endif
        checks++;
        if (q.size() != 0) begin
          failures++;
          $display("FAIL early_done got remaining=%0d want 0", q.size());
        end
      end
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          failures++;
          $display("FAIL idle_after_done got busy=%0b done=%0b want 0 0", busy, done);
        end
        break;
      end
      pv = m_valid; prdy = rdy; pd = m_data; pr = m_row; pc = m_col; pl = m_last;
      if (stop_beats > 0 && nbeats >= stop_beats) break;
    end
    if (stop_beats == 0) begin
      checks++;
      if (done_cyc < 0 || q.size() != 0) begin
        failures++;
        $display("FAIL drain_timeout got done_cycle=%0d remaining=%0d want done and 0", done_cyc, q.size());
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({z_i, z_j, m_valid, m_data, m_row, m_col, m_last, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got z=(%0d,%0d) v=%0b d=%0h busy=%0b done=%0b want all 0",
               z_i, z_j, m_valid, m_data, busy, done);
    end
`ifdef STREAM_CHECKSUM_EN
    checks++;
    if (checksum !== '0) begin
      failures++;
      $display("FAIL reset_checksum got %0h want 0", checksum);
    end
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%0b done=%0b valid=%0b want 0 0 0", busy, done, m_valid);
    end
  endtask

  task automatic test_stream();
    int dc, fv, nb;
    logic [DW-1:0] ck;
    fill_formula();
    drain(0, 0, 0, dc, fv, nb, ck);
    checks++;
    if (fv != 2 || dc != 18 || nb != 16) begin
      failures++;
      $display("FAIL stream_timing got first_valid=%0d done=%0d beats=%0d want 2 18 16", fv, dc, nb);
    end
  endtask

  task automatic test_toggle();
    int dc, fv, nb;
    logic [DW-1:0] ck;
    fill_random();
    drain(1, 0, 0, dc, fv, nb, ck);
    checks++;
    if (nb != 16 || dc != 49) begin
      failures++;
      $display("FAIL toggle_timing got beats=%0d done=%0d want 16 49", nb, dc);
    end
  endtask

  task automatic test_full_stall();
    int dc, fv, nb;
    logic [DW-1:0] ck;
    fill_random();
    drain(3, 0, 0, dc, fv, nb, ck);
    checks++;
    if (nb != 16 || dc != 37) begin
      failures++;
      $display("FAIL stall_release got beats=%0d done=%0d want 16 37", nb, dc);
    end
  endtask

  task automatic test_random_ready();
    int dc, fv, nb;
    logic [DW-1:0] ck;
    for (int r = 0; r < 3; r++) begin
      fill_random();
      drain(2, 0, 0, dc, fv, nb, ck);
      checks++;
      if (nb != 16 || fv != 2) begin
        failures++;
        $display("FAIL random_ready run%0d got beats=%0d first_valid=%0d want 16 2", r, nb, fv);
      end
    end
  endtask

  task automatic test_restart_reset();
    int dc, fv, nb;
    logic [DW-1:0] ck;
    bit saw_done;
    fill_random();
    drain(0, 6, 5, dc, fv, nb, ck);
    checks++;
    if (nb != 6 || dc != -1) begin
      failures++;
      $display("FAIL pre_abort got beats=%0d done=%0d want 6 -1", nb, dc);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({z_i, z_j, m_valid, m_data, m_row, m_col, m_last, busy, done} !== '0) begin
      failures++;
      $display("FAIL abort_outputs got z=(%0d,%0d) v=%0b d=%0h busy=%0b done=%0b want all 0",
               z_i, z_j, m_valid, m_data, busy, done);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || busy || m_valid) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL no_replay got activity=1 want 0");
    end
    fill_random();
    drain(0, 0, 0, dc, fv, nb, ck);
    checks++;
    if (fv != 2 || dc != 18 || nb != 16) begin
      failures++;
      $display("FAIL fresh_drain got first_valid=%0d done=%0d beats=%0d want 2 18 16", fv, dc, nb);
    end
  endtask

`ifdef STREAM_CHECKSUM_EN
  task automatic test_checksum();
    int dc, fv, nb;
    logic [DW-1:0] ck, want;
    for (int r = 0; r < 3; r++) begin
      if (r == 0) fill_formula();
      else if (r == 1) for (int k = 0; k < N*N; k++) zmem[k] = 32'hFFFF_FFFF;
      else fill_random();
      want = model_sum();
      drain(r == 2 ? 2 : 0, 0, 0, dc, fv, nb, ck);
      checks++;
      if (ck !== want) begin
        failures++;
        $display("FAIL checksum run%0d got %0h want %0h", r, ck, want);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (checksum !== want) begin
        failures++;
        $display("FAIL checksum_hold run%0d got %0h want %0h", r, checksum, want);
      end
    end
  endtask
`endif

  initial begin
    fill_formula();
    test_reset();
    test_stream();
    test_toggle();
    test_full_stall();
    test_random_ready();
    test_restart_reset();
`ifdef STREAM_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
